// File: rtl/ow_txn_ctrl.sv
// ow_txn_ctrl -- 1-Wire byte-level transaction controller.
//
// Takes host requests (bus reset, write byte, read byte, read bit) over a
// valid/ready handshake. Each request is split into LSB-first RESET/WRITE/READ
// slot commands for the bit timing engine. Every slot is followed by a
// programmable recovery gap. One response comes back per request.
//
// Parameters
//   T_REC    idle cycles (eng_cmd = IDLE) after each slot, 1..255
//   TIMEOUT  max WAIT cycles per slot before a timeout error (16-bit)
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   req_valid/ready     host request handshake (ready only in IDLE)
//   req_op, req_data    00 RESET, 01 WRITE_BYTE, 10 READ_BYTE, 11 READ_BIT
//   resp_valid          one-cycle pulse per completed request
//   resp_data, resp_err response payload / timeout flag (held until next)
//   busy                high outside IDLE
//   eng_cmd             engine command 00 IDLE, 01 RESET, 10 WRITE, 11 READ
//   eng_write_bit       bit driven in the current WRITE slot
//   eng_read_bit        engine read/presence value, valid with eng_done
//   eng_busy            engine status, informational only
//   eng_done            engine slot-complete pulse
module ow_txn_ctrl #(
  parameter int T_REC   = 2,
  parameter int TIMEOUT = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic [7:0] req_data,
  output logic       resp_valid,
  output logic [7:0] resp_data,
  output logic       resp_err,
  output logic       busy,
  output logic [1:0] eng_cmd,
  output logic       eng_write_bit,
  input  logic       eng_read_bit,
  input  logic       eng_busy,
  input  logic       eng_done
);

  localparam logic [1:0] OP_RESET = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_RBYTE = 2'b10;
  localparam logic [1:0] OP_RBIT  = 2'b11;

  localparam logic [15:0] WD_LAST  = 16'(TIMEOUT - 1);
  localparam logic [7:0]  REC_LOAD = 8'(T_REC);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RECOVER, S_ERROR} state_t;

  state_t      r_state;
  logic [1:0]  r_op;
  logic [7:0]  r_data;
  logic [3:0]  r_bit_cnt;
  logic [3:0]  r_n;
  logic [7:0]  r_sreg;
  logic [15:0] r_wd;
  logic [7:0]  r_rec;

  // Engine status is not needed for sequencing; eng_done is authoritative.
  logic w_unused;
  assign w_unused = eng_busy;

  function automatic logic [1:0] cmd_of(input logic [1:0] op);
    case (op)
      OP_RESET: cmd_of = 2'b01;
      OP_WRITE: cmd_of = 2'b10;
      default:  cmd_of = 2'b11;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      req_ready     <= 1'b1;
      resp_valid    <= 1'b0;
      resp_data     <= 8'h00;
      resp_err      <= 1'b0;
      busy          <= 1'b0;
      eng_cmd       <= 2'b00;
      eng_write_bit <= 1'b0;
      r_op          <= OP_RESET;
      r_data        <= 8'h00;
      r_bit_cnt     <= 4'd0;
      r_n           <= 4'd0;
      r_sreg        <= 8'h00;
      r_wd          <= 16'd0;
      r_rec         <= 8'd0;
    end else begin
      resp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            r_op          <= req_op;
            r_data        <= req_data;
            r_bit_cnt     <= 4'd0;
            r_n           <= (req_op == OP_RESET || req_op == OP_RBIT) ? 4'd1 : 4'd8;
            r_sreg        <= 8'h00;
            eng_cmd       <= cmd_of(req_op);
            eng_write_bit <= req_data[0];
            r_wd          <= 16'd0;
            req_ready     <= 1'b0;
            busy          <= 1'b1;
            r_state       <= S_WAIT;
          end
        end

        S_WAIT: begin
          // A done arriving on the timeout cycle still completes the slot.
          if (eng_done) begin
            eng_cmd   <= 2'b00;
            r_sreg    <= (r_op == OP_RBYTE) ? {eng_read_bit, r_sreg[7:1]}
                                            : {7'b0, eng_read_bit};
            r_bit_cnt <= r_bit_cnt + 4'd1;
            r_rec     <= REC_LOAD;
            r_state   <= S_RECOVER;
          end else if (r_wd == WD_LAST) begin
            eng_cmd    <= 2'b00;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_data  <= 8'h00;
            r_state    <= S_ERROR;
          end else begin
            r_wd <= r_wd + 16'd1;
          end
        end

        S_RECOVER: begin
          // Loaded with T_REC on done; acting when it reads 1 gives exactly
          // T_REC idle cycles on eng_cmd before the next issue/response.
          if (r_rec > 8'd1) begin
            r_rec <= r_rec - 8'd1;
          end else begin
            r_rec <= 8'd0;
            if (r_bit_cnt < r_n) begin
              eng_cmd       <= cmd_of(r_op);
              eng_write_bit <= r_data[r_bit_cnt[2:0]];
              r_wd          <= 16'd0;
              r_state       <= S_WAIT;
            end else begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
              resp_data  <= (r_op == OP_WRITE) ? 8'h00 : r_sreg;
              req_ready  <= 1'b1;
              busy       <= 1'b0;
              r_state    <= S_IDLE;
            end
          end
        end

        default: begin
          // Sticky error: only rst leaves this state.
          req_ready <= 1'b0;
          busy      <= 1'b1;
          eng_cmd   <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ow_txn_ctrl.sv
module tb_ow_txn_ctrl;
  localparam int T_REC   = 2;
  localparam int TIMEOUT = 50;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_op = 2'b00;
  logic [7:0] req_data = 8'h00;
  logic       resp_valid;
  logic [7:0] resp_data;
  logic       resp_err;
  logic       busy;
  logic [1:0] eng_cmd;
  logic       eng_write_bit;
  logic       eng_read_bit = 1'b0;
  logic       eng_busy = 1'b0;
  logic       eng_done = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  ow_txn_ctrl #(.T_REC(T_REC), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_data(req_data),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .busy(busy),
    .eng_cmd(eng_cmd), .eng_write_bit(eng_write_bit),
    .eng_read_bit(eng_read_bit), .eng_busy(eng_busy), .eng_done(eng_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout obs=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour: a request of op produces n slots of command ecmd;
  // write bits are data LSB-first; the response is the read bits packed
  // LSB-first (byte), the single bit (bit/reset), or zero (write).
  task automatic txn(input logic [1:0] op, input logic [7:0] data, input logic [7:0] rbits,
                     input bit pre_acc, input bit hold_next, input logic [1:0] nop,
                     input logic [7:0] ndata, input int abort_slot);
    int n, cnt, d;
    logic [1:0] ecmd;
    logic [7:0] exp_data;
    bit stable;
    n    = (op == 2'b00 || op == 2'b11) ? 1 : 8;
    ecmd = (op == 2'b00) ? 2'b01 : (op == 2'b01) ? 2'b10 : 2'b11;
    exp_data = 8'h00;
    if (op == 2'b10) for (int k = 0; k < 8; k++) exp_data = exp_data + 8'(rbits[k] * (1 << k));
    else if (op != 2'b01) exp_data = {7'b0, rbits[0]};

    if (!pre_acc) begin
      chk("req_ready_idle", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_op = op; req_data = data;
    end
    @(negedge clk);
    if (hold_next) begin req_op = nop; req_data = ndata; end
    else req_valid = 1'b0;
    chk("issue_lat_cmd", 32'(eng_cmd), 32'(ecmd));
    chk("busy_after_accept", 32'(busy), 32'd1);
    chk("ready_low_busy", 32'(req_ready), 32'd0);
    chk("resp_pulse_one", 32'(resp_valid), 32'd0);

    for (int k = 0; k < n; k++) begin
      if (op == 2'b01) chk("write_bit", 32'(eng_write_bit), 32'(data[k]));
      if (k == abort_slot) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_cmd", 32'(eng_cmd), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ready", 32'(req_ready), 32'd1);
        chk("abort_resp", 32'(resp_valid), 32'd0);
        return;
      end
      d = $urandom_range(0, 5);
      stable = 1'b1;
      repeat (d) begin
        @(negedge clk);
        if (eng_cmd !== ecmd || resp_valid !== 1'b0) stable = 1'b0;
      end
      chk("cmd_hold", 32'(stable), 32'd1);
      eng_done = 1'b1; eng_read_bit = rbits[k];
      @(negedge clk);
      eng_done = 1'b0; eng_read_bit = 1'($urandom);
      chk("cmd_clr_after_done", 32'(eng_cmd), 32'd0);
      cnt = 1;
      while (eng_cmd === 2'b00 && resp_valid !== 1'b1 && cnt < 100) begin
        @(negedge clk);
        cnt++;
      end
      chk("recovery_gap", 32'(cnt), 32'(T_REC + 1));
      if (k < n - 1) begin
        chk("cmd_next_slot", 32'(eng_cmd), 32'(ecmd));
      end else begin
        chk("resp_valid", 32'(resp_valid), 32'd1);
        chk("resp_err", 32'(resp_err), 32'd0);
        chk("resp_data", 32'(resp_data), 32'(exp_data));
        chk("ready_with_resp", 32'(req_ready), 32'd1);
        chk("cmd_idle_at_resp", 32'(eng_cmd), 32'd0);
      end
    end
  endtask

  initial begin
    int cnt;
    logic [1:0] rop;
    // Reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_data", 32'(resp_data), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cmd", 32'(eng_cmd), 32'd0);
    chk("rst_wbit", 32'(eng_write_bit), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // eng_done outside WAIT is ignored
    eng_done = 1'b1;
    @(negedge clk);
    eng_done = 1'b0;
    chk("idle_done_ignored_resp", 32'(resp_valid), 32'd0);
    chk("idle_done_ignored_cmd", 32'(eng_cmd), 32'd0);

    // Directed cases
    txn(2'b00, 8'h00, 8'h01, 0, 0, 2'b00, 8'h00, 8);   // RESET, presence
    txn(2'b01, 8'hA5, 8'h00, 0, 0, 2'b00, 8'h00, 8);   // WRITE_BYTE A5
    txn(2'b10, 8'h00, 8'h2C, 0, 0, 2'b00, 8'h00, 8);   // READ_BYTE -> 2C
    chk("read_byte_2c", 32'(resp_data), 32'h2C);
    txn(2'b11, 8'h00, 8'h01, 0, 1, 2'b01, 8'h01, 8);   // READ_BIT, next held
    txn(2'b01, 8'h01, 8'h00, 1, 0, 2'b00, 8'h00, 8);   // WRITE_BYTE 01 back-to-back

    // Randomized requests
    for (int i = 0; i < 12; i++) begin
      rop = 2'($urandom);
      txn(rop, 8'($urandom), 8'($urandom), 0, 0, 2'b00, 8'h00, 8);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Reset in the 4th slot of a write, then a fresh RESET
    txn(2'b01, 8'h5A, 8'h00, 0, 0, 2'b00, 8'h00, 3);
    txn(2'b00, 8'h00, 8'h00, 0, 0, 2'b00, 8'h00, 8);

    // Timeout: engine never answers
    req_valid = 1'b1; req_op = 2'b11;
    @(negedge clk);
    req_valid = 1'b0;
    cnt = 0;
    while (eng_cmd === 2'b11 && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    chk("timeout_wait_cycles", 32'(cnt), 32'(TIMEOUT));
    chk("timeout_resp_valid", 32'(resp_valid), 32'd1);
    chk("timeout_resp_err", 32'(resp_err), 32'd1);
    chk("timeout_resp_data", 32'(resp_data), 32'd0);
    chk("timeout_cmd", 32'(eng_cmd), 32'd0);
    chk("timeout_ready", 32'(req_ready), 32'd0);
    req_valid = 1'b1; eng_done = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("error_ready", 32'(req_ready), 32'd0);
      chk("error_busy", 32'(busy), 32'd1);
      chk("error_resp", 32'(resp_valid), 32'd0);
      chk("error_cmd", 32'(eng_cmd), 32'd0);
    end
    req_valid = 1'b0; eng_done = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("post_err_rst_ready", 32'(req_ready), 32'd1);
    chk("post_err_rst_err", 32'(resp_err), 32'd0);
    txn(2'b10, 8'h00, 8'h96, 0, 0, 2'b00, 8'h00, 8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ow_txn_ctrl.md
# ow_txn_ctrl

Byte-level transaction controller that sequences the 1-Wire bit timing engine. It accepts host requests (bus reset, write byte, read byte, read bit) over a valid/ready handshake. It breaks each request into individual RESET/WRITE/READ slot commands, issued LSB-first, and inserts a programmable recovery gap between slots. It returns one response per request, carrying assembled read data, presence status, or a timeout error. It sits between the host/command layer and the bit engine; it never touches the bus pin itself.

## Interface
- T_REC, 2: idle cycles between consecutive slots with engine cmd = IDLE; legal range 1..255.
- TIMEOUT, 2000: max cycles to wait for eng_done per slot; 16-bit; must exceed the longest slot (reset).
- clk  in  1  system clock (1 MHz, 1 tick = 1 µs).
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  1  host request valid.
- req_ready  out  1  high only in IDLE; request accepted on req_valid && req_ready.
- req_op  in  2  00 = RESET, 01 = WRITE_BYTE, 10 = READ_BYTE, 11 = READ_BIT.
- req_data  in  8  byte to write (WRITE_BYTE only).
- resp_valid  out  1  one-cycle pulse per completed request.
- resp_data  out  8  READ_BYTE: assembled byte; READ_BIT: {7'b0, bit}; RESET: {7'b0, presence}; WRITE_BYTE: 8'h00.
- resp_err  out  1  qualifies resp_valid; 1 = slot timeout.
- busy  out  1  high in every state except IDLE.
- eng_cmd  out  2  engine command (00 IDLE, 01 RESET, 10 WRITE, 11 READ); registered.
- eng_write_bit  out  1  bit for the current WRITE slot; registered.
- eng_read_bit  in  1  engine latched read/presence value; valid in the eng_done cycle.
- eng_busy  in  1  engine active (status only, not used for sequencing).
- eng_done  in  1  engine slot-complete pulse.

## Operation
- States: IDLE, WAIT, RECOVER, ERROR.
- Reset values: state = IDLE, req_ready = 1, resp_valid = 0, resp_data = 0, resp_err = 0, busy = 0, eng_cmd = 00, eng_write_bit = 0, bit_cnt = 0, shift register = 0, watchdog = 0.
- IDLE, on accept:
  - Latch op and data.
  - Set bit_cnt = 0 and the number of slots N: 1 for RESET and READ_BIT, 8 for byte ops.
  - Register eng_cmd = mapped command and eng_write_bit = req_data[0].
  - Clear the watchdog and go to WAIT.
- WAIT, on eng_done:
  - Register eng_cmd = 00.
  - Shift in eng_read_bit: sreg <= {eng_read_bit, sreg[7:1]} for byte reads; direct capture for READ_BIT and RESET.
  - Increment bit_cnt and load the recovery counter with T_REC.
  - Go to RECOVER.
- WAIT, watchdog reaching TIMEOUT without eng_done:
  - Register eng_cmd = 00.
  - Pulse resp_valid with resp_err = 1 and resp_data = 0.
  - Go to ERROR.
- RECOVER:
  - Count down T_REC cycles with eng_cmd = 00.
  - At zero, if bit_cnt < N: register eng_cmd again, set eng_write_bit = data[bit_cnt], clear the watchdog, and go to WAIT.
  - At zero, if bit_cnt == N: pulse resp_valid with resp_err = 0 and the final resp_data, and go to IDLE.
- ERROR: sticky. req_ready = 0, busy = 1. Only rst exits.
- Presence for RESET is eng_read_bit as delivered by the engine: 1 = device present.
- Read byte is LSB-first: the first slot lands in resp_data[0].
- The controller never issues a new slot without eng_cmd having been 00 for at least T_REC ≥ 1 cycles after eng_done.

## Timing
- Accept edge to eng_cmd valid: 1 cycle (registered).
- eng_cmd is held constant from issue until the cycle after eng_done.
- resp_valid arrives exactly T_REC + 1 cycles after the final eng_done (last-slot done, recovery countdown, then the response edge). resp_valid is high for exactly 1 cycle; resp_data and resp_err hold until the next response.
- req_ready rises in the same cycle as resp_valid, so back-to-back requests are accepted the cycle resp_valid is high.
- Watchdog counts WAIT cycles from 0. Timeout fires when count == TIMEOUT-1, on the same cycle as a late eng_done: eng_done wins.
- eng_done outside WAIT is ignored.
- req_valid while busy is ignored; it is not queued.
- rst mid-slot: all outputs return to reset values on the next edge, and eng_cmd = 00 immediately after that edge.

## Test plan
- RESET with model device present (eng_read_bit = 1 at done): exactly one RESET slot issued; resp_valid once T_REC + 1 cycles after eng_done; resp_data = 8'h01, resp_err = 0.
- WRITE_BYTE 8'hA5: 8 WRITE slots with eng_write_bit sequence 1,0,1,0,0,1,0,1; eng_cmd = 00 for exactly T_REC cycles between slots; resp_data = 8'h00.
- READ_BYTE with model returning bits 0,0,1,1,0,1,0,0 (first to last): resp_data = 8'h2C; 8 READ slots observed.
- Back-to-back READ_BIT then WRITE_BYTE 8'h01 with req_valid held high: second request accepted in the resp_valid cycle of the first; no slot overlap.
- Engine never asserts eng_done, TIMEOUT = 50: resp_valid with resp_err = 1 on the 50th WAIT cycle; eng_cmd = 00; req_ready stays 0 until rst.
- rst asserted in the 4th slot of a WRITE_BYTE: next edge gives eng_cmd = 00, busy = 0, req_ready = 1, no resp_valid; a fresh RESET request then completes normally.
